// File: rtl/hist_reader.sv
// hist_reader: streams a histogram RAM out as a header / big-endian bins / XOR-checksum byte frame
module hist_reader #(
    parameter int         N     = 16,
    parameter int         DEPTH = 1024,
    parameter logic [7:0] HDR   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [9:0]   read_addr,
    input  logic [N-1:0] r_data,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done
);
    localparam int              NB    = N / 8;
    localparam int              BW    = $clog2(NB) + 1;
    localparam logic [9:0]      LAST  = 10'(DEPTH - 1);
    localparam logic [BW-1:0]   BLAST = BW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SETUP, S_WAIT, S_LOAD, S_SEND, S_CSUM, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    idx_q, idx_d;
    logic [9:0]    addr_q, addr_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [7:0]    csum_q, csum_d;

    assign read_addr = addr_q;

    // frame sequencer: next state, datapath updates and Moore-style stream outputs
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        csum_d   = csum_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    csum_d  = 8'h00;
                    idx_d   = 10'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (tx_ready) state_d = S_SETUP;
            end
            S_SETUP: begin
                addr_d  = idx_q;
                state_d = S_WAIT;
            end
            S_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = r_data;
                bcnt_d  = BLAST;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[N-1 -: 8];
                if (tx_ready) begin
                    csum_d  = csum_q ^ shift_q[N-1 -: 8];
                    shift_d = shift_q << 8;
                    if (bcnt_q == '0) begin
                        if (idx_q == LAST) state_d = S_CSUM;
                        else begin
                            idx_d   = idx_q + 10'd1;
                            state_d = S_SETUP;
                        end
                    end else bcnt_d = bcnt_q - 1'b1;
                end
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            bcnt_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            csum_q  <= csum_d;
        end
    end
endmodule

// File: tb/tb_hist_reader.sv
// tb_hist_reader: scoreboard bench for hist_reader (default 16x1024 instance and an 8-bit x 4 instance)
module tb_hist_reader;
    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, tx_ready = 1'b0;
    logic       tx_valid, busy, done;
    logic [9:0] read_addr;
    logic [15:0] r_data;
    logic [7:0] tx_data;
    logic       s_start = 1'b0, s_tx_ready = 1'b1, s_tx_valid, s_busy, s_done;
    logic [9:0] s_read_addr;
    logic [7:0] s_r_data, s_tx_data;
    logic [15:0] mem [1024];
    logic [7:0] smem [4];
    logic [7:0] exp_q[$], exp_s[$];
    int checks = 0, errors = 0, nbytes = 0, ndone = 0, s_nbytes = 0, cyc;
    bit rand_ready = 1'b0;

    hist_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .read_addr(read_addr), .r_data(r_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    hist_reader #(.N(8), .DEPTH(4), .HDR(8'hA5)) sdut (
        .clk(clk), .rst_n(rst_n), .start(s_start), .read_addr(s_read_addr), .r_data(s_r_data),
        .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    // synchronous RAM models: one clock of read latency
    always @(posedge clk) begin
        r_data   <= mem[read_addr];
        s_r_data <= smem[s_read_addr[1:0]];
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    end

    // monitor for the default instance: pops the scoreboard on each handshake, checks stall stability
    initial begin
        logic [7:0] w, held;
        bit stall_p;
        stall_p = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_p = 1'b0;
                continue;
            end
            if (stall_p) begin
                checks++;
                if (!tx_valid || tx_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h", tx_valid, tx_data, held);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %02h, want no byte", tx_data);
                end else begin
                    w = exp_q.pop_front();
                    if (tx_data !== w) begin
                        errors++;
                        $display("FAIL byte[%0d]: got %02h, want %02h", nbytes, tx_data, w);
                    end
                end
                nbytes++;
            end
            stall_p = tx_valid && !tx_ready;
            held = tx_data;
            if (done) ndone++;
        end
    end

    // monitor for the small instance, including the two-clock read-address relation
    initial begin
        logic [7:0] w;
        logic [9:0] ra1, ra2;
        ra1 = '0;
        ra2 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            checks++;
            if (s_read_addr > 10'd3) begin
                errors++;
                $display("FAIL s_addr_range: got %0d, want <= 3", s_read_addr);
            end
            if (s_tx_valid) begin
                checks++;
                if (exp_s.size() == 0) begin
                    errors++;
                    $display("FAIL s_extra_byte: got %02h, want no byte", s_tx_data);
                end else begin
                    w = exp_s.pop_front();
                    if (s_tx_data !== w) begin
                        errors++;
                        $display("FAIL s_byte[%0d]: got %02h, want %02h", s_nbytes, s_tx_data, w);
                    end
                end
                if (s_nbytes >= 1 && s_nbytes <= 4) begin
                    checks++;
                    if (s_tx_data !== smem[ra2[1:0]]) begin
                        errors++;
                        $display("FAIL s_addr_timing: got %02h, want %02h", s_tx_data, smem[ra2[1:0]]);
                    end
                end
                s_nbytes++;
            end
            ra2 = ra1;
            ra1 = s_read_addr;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push_frame();
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
            cs ^= mem[i][15:8] ^ mem[i][7:0];
        end
        exp_q.push_back(cs);
    endtask

    task automatic start_frame();
        nbytes = 0;
        ndone = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        bit busy_ok;
        busy_ok = 1'b1;
        n = 0;
        while (!done && n < budget) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", int'(done), 1);
        chk("busy_during_frame", int'(busy_ok), 1);
        chk("busy_at_done", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic wait_addr(input logic [9:0] a);
        int n;
        n = 0;
        while (read_addr != a && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_addr", int'(read_addr), int'(a));
    endtask

    task automatic end_frame_checks();
        chk("frame_bytes", nbytes, 2050);
        chk("done_pulses", ndone, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        smem[0] = 8'h01; smem[1] = 8'h02; smem[2] = 8'h04; smem[3] = 8'h08;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_read_addr", int'(read_addr), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("s_rst_read_addr", int'(s_read_addr), 0);
        chk("s_rst_tx_valid", int'(s_tx_valid), 0);
        chk("s_rst_busy", int'(s_busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        push_frame();
        start_frame();
        wait_done(6000, cyc);
        chk("ramp_cycles", cyc, 1024 * (3 + 2) + 4 - 2);
        end_frame_checks();
        for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
        push_frame();
        rand_ready = 1'b1;
        start_frame();
        wait_done(30000, cyc);
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        end_frame_checks();
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        @(posedge clk);
        #1;
        push_frame();
        start_frame();
        wait_addr(10'd100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6000, cyc);
        end_frame_checks();
        push_frame();
        start_frame();
        wait_addr(10'd500);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", int'(tx_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_read_addr", int'(read_addr), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_no_done", ndone, 0);
        @(posedge clk);
        #1;
        push_frame();
        start_frame();
        wait_done(6000, cyc);
        end_frame_checks();
        foreach (smem[i]) exp_s.push_back(smem[i]);
        exp_s.push_back(8'h0F);
        exp_s.push_front(8'hA5);
        s_nbytes = 0;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        cyc = 0;
        while (!s_done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("s_cycles", cyc, 4 * (3 + 1) + 4 - 2);
        chk("s_frame_bytes", s_nbytes, 6);
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        chk("s_start_at_done_ignored", int'(s_busy), 0);
        exp_s.push_back(8'hA5);
        foreach (smem[i]) exp_s.push_back(smem[i]);
        exp_s.push_back(8'h0F);
        s_nbytes = 0;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        chk("s_restart_busy", int'(s_busy), 1);
        cyc = 0;
        while (!s_done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("s_restart_done", int'(s_done), 1);
        @(posedge clk);
        #1;
        chk("s_restart_bytes", s_nbytes, 6);
        chk("s_queue_empty", exp_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hist_reader.md
HIST_READER -- requirements
Module: hist_reader

Interface
REQ-001 Parameter N, default 16, histogram word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 1024, number of histogram bins; SHALL be a power of two and at most 1024.
REQ-003 Parameter HDR, default 8'hA5, frame header byte.
REQ-004 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to dump the histogram.
REQ-007 read_addr  out  10  bin address driven to the histogram RAM read port; SHALL be a registered output.
REQ-008 r_data  in  N  RAM read data, registered by the RAM on the same clk, one clock of latency after read_addr.
REQ-009 tx_data  out  8  stream byte.
REQ-010 tx_valid  out  1  tx_data is valid.
REQ-011 tx_ready  in  1  downstream accepts the byte.
REQ-012 busy  out  1  high from the accepted start until the end of the frame.
REQ-013 done  out  1  one-cycle pulse after the last frame byte is accepted.

Function
REQ-014 Frame byte order SHALL be: HDR, then bins 0..DEPTH-1 each as N/8 bytes most-significant byte first, then one checksum byte.
REQ-015 Checksum SHALL be the XOR of every data byte, excluding HDR.
REQ-016 States SHALL be IDLE, HDR, SETUP, WAIT, LOAD, SEND, CSUM, DONE.
REQ-017 IDLE: start=1 SHALL set busy, clear the checksum, set the bin index to 0 and go to HDR; start is ignored in every other state.
REQ-018 HDR: tx_valid=1 with tx_data=HDR; on tx_ready go to SETUP.
REQ-019 SETUP: read_addr SHALL take the bin index; next state WAIT.
REQ-020 WAIT: a single latency cycle with no outputs changed; next state LOAD.
REQ-021 LOAD: r_data SHALL be captured into an N-bit shift register, the byte counter SHALL be set to N/8-1, and the next state is SEND.
REQ-022 SEND: tx_valid=1 with tx_data = shift register [N-1:N-8].
  - On tx_ready, XOR the byte into the checksum and shift left by 8.
  - If the byte counter is 0: go to CSUM if the bin index is DEPTH-1, otherwise increment the index and go to SETUP.
  - Otherwise decrement the byte counter.
REQ-023 CSUM: tx_valid=1 with tx_data=checksum; on tx_ready go to DONE.
REQ-024 DONE: done=1 and busy=0 for one cycle, then return to IDLE.
REQ-025 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable and tx_valid SHALL NOT drop.
REQ-026 tx_valid SHALL be 0 in IDLE, SETUP, WAIT, LOAD and DONE.
REQ-027 The bin index SHALL NOT wrap: after bin DEPTH-1 the block goes to CSUM, never back to bin 0.
REQ-028 A start asserted in the same cycle as done SHALL be ignored; a start one cycle later SHALL begin a new frame.
REQ-029 read_addr SHALL hold its last value outside SETUP.
REQ-030 Minimum frame length SHALL be 2 + DEPTH*N/8 bytes; with tx_ready tied high it SHALL take DEPTH*(3+N/8) + 4 cycles from start to done.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, read_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, checksum=0, shift register=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse; the partial frame is not resumed.
REQ-033 After release of rst_n, the first start accepted SHALL produce a complete frame.

Verification
REQ-034 Model the RAM with bin i = i, tx_ready=1, pulse start -> 2050 bytes: A5, 00 00, 00 01, ..., 03 FF, then a checksum equal to the model XOR; busy high throughout; done pulses once.
REQ-035 Set all bins to 16'hFFFF, toggle tx_ready randomly -> every byte FF except the header; checksum 00; tx_data stable across every stall.
REQ-036 Pulse start again while busy at bin 100 -> no restart, frame byte count unchanged.
REQ-037 Drop rst_n at bin 500 -> tx_valid=0 and busy=0 at once, no done pulse; the next start yields a full 2050-byte frame starting with A5.
REQ-038 Use N=8, DEPTH=4, bins 01 02 04 08 -> bytes A5 01 02 04 08 0F.
REQ-039 Check read_addr timing -> each byte sent equals the RAM content at the address driven two clocks earlier; read_addr never exceeds DEPTH-1.
